// File: rtl/instr_encoder_loader.sv
// Packs decoded MIPS fields into 32-bit words, buffers them and streams them into RAM at consecutive addresses.
// First write one cycle after the push into an empty FIFO; enc_ready drops when full, after the last word, or in DONE.
module instr_encoder_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      if (push_vld && !pop)      count <= count + 1'b1;
      else if (!push_vld && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
endmodule

module instr_encoder_loader #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          MAX_WORDS  = 1024
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        enc_valid,
  output logic        enc_ready,
  input  logic [5:0]  enc_opcode,
  input  logic [4:0]  enc_rs,
  input  logic [4:0]  enc_rt,
  input  logic [4:0]  enc_rd,
  input  logic [4:0]  enc_shamt,
  input  logic [5:0]  enc_funct,
  input  logic [15:0] enc_imm16,
  input  logic [25:0] enc_imm26,
  input  logic        enc_last,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_store,
  input  logic        mem_wait,
  input  logic        clear,
  output logic        done,
  output logic        overflow,
  output logic [15:0] word_count
);
  localparam logic [5:0]  OP_RTYPE = 6'h00;
  localparam logic [5:0]  OP_J     = 6'h02;
  localparam logic [5:0]  OP_JAL   = 6'h03;
  localparam logic [5:0]  OP_HALT  = 6'h3F;
  localparam logic [15:0] MAX_CNT  = 16'(MAX_WORDS);
  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t state, state_nxt;

  logic [31:0]   enc_word;
  logic [32:0]   head_dat;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          push;
  logic          pop;
  logic          flush;
  logic          last_seen;
  logic          set_overflow;
  logic [31:0]   addr_reg;

  always_comb begin
    enc_word = {enc_opcode, enc_rs, enc_rt, enc_imm16};
    case (enc_opcode)
      OP_RTYPE:     enc_word = {6'b0, enc_rs, enc_rt, enc_rd, enc_shamt, enc_funct};
      OP_J, OP_JAL: enc_word = {enc_opcode, enc_imm26};
      OP_HALT:      enc_word = {OP_HALT, 26'b0};
      default:      enc_word = {enc_opcode, enc_rs, enc_rt, enc_imm16};
    endcase
  end

  // Gated by nRST so the producer sees no ready while reset is held.
  assign enc_ready = nRST && !fifo_full && (state != DONE) && !last_seen;
  assign push      = enc_valid && enc_ready;
  assign pop       = (state == WRITE) && !mem_wait;
  assign flush     = (state == DONE) && clear;

  instr_encoder_fifo #(
    .WIDTH (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (nRST),
    .flush    (flush),
    .push_vld (push),
    .push_dat ({enc_last, enc_word}),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    state_nxt    = state;
    mem_wen      = 1'b0;
    done         = 1'b0;
    set_overflow = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) state_nxt = WRITE;
      end
      WRITE: begin
        mem_wen = 1'b1;
        if (!mem_wait) begin
          if (head_dat[32]) begin
            state_nxt = DONE;
          end else if (word_count + 16'd1 == MAX_CNT) begin
            set_overflow = 1'b1;
            state_nxt    = DONE;
          end else if (fifo_count == CW'(1) && !push) begin
            state_nxt = IDLE;
          end
        end
      end
      DONE: begin
        done = 1'b1;
        if (clear) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      addr_reg   <= BASE_ADDR;
      word_count <= '0;
      overflow   <= 1'b0;
      last_seen  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        addr_reg   <= BASE_ADDR;
        word_count <= '0;
        overflow   <= 1'b0;
        last_seen  <= 1'b0;
      end else begin
        if (pop) begin
          addr_reg   <= addr_reg + 32'd4;
          word_count <= word_count + 16'd1;
        end
        if (set_overflow)     overflow  <= 1'b1;
        if (push && enc_last) last_seen <= 1'b1;
      end
    end
  end

  assign mem_addr  = addr_reg;
  assign mem_store = (state == WRITE) ? head_dat[31:0] : 32'h0;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: queue-based reference model checked every cycle, directed literal cases, then random traffic.
`timescale 1ns/1ps
module tb_instr_encoder_loader;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0040;
  localparam int          MAXW  = 8;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        enc_valid = 1'b0;
  logic        enc_ready;
  logic [5:0]  enc_opcode = '0;
  logic [4:0]  enc_rs = '0, enc_rt = '0, enc_rd = '0, enc_shamt = '0;
  logic [5:0]  enc_funct = '0;
  logic [15:0] enc_imm16 = '0;
  logic [25:0] enc_imm26 = '0;
  logic        enc_last = 1'b0;
  logic        mem_wen;
  logic [31:0] mem_addr, mem_store;
  logic        mem_wait = 1'b0;
  logic        clear = 1'b0;
  logic        done, overflow;
  logic [15:0] word_count;

  always #5 CLK = ~CLK;

  instr_encoder_loader #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .CLK(CLK), .nRST(nRST), .enc_valid(enc_valid), .enc_ready(enc_ready),
    .enc_opcode(enc_opcode), .enc_rs(enc_rs), .enc_rt(enc_rt), .enc_rd(enc_rd),
    .enc_shamt(enc_shamt), .enc_funct(enc_funct), .enc_imm16(enc_imm16),
    .enc_imm26(enc_imm26), .enc_last(enc_last), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_store(mem_store), .mem_wait(mem_wait),
    .clear(clear), .done(done), .overflow(overflow), .word_count(word_count)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    $display("FAIL %s: no response within cycle budget (cycle %0d)", name, cyc);
    finish_run();
  endtask

  function automatic logic [31:0] encode(input logic [5:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
      input logic [15:0] i16, input logic [25:0] i26);
    if (op == 6'h00) return {6'h00, rs, rt, rd, sh, fn};
    if (op == 6'h02 || op == 6'h03) return {op, i26};
    if (op == 6'h3F) return 32'hFC00_0000;
    return {op, rs, rt, i16};
  endfunction

  // Reference model: pending words in order, plus program-level flags.
  logic [32:0] exp_q[$];
  logic [32:0] ent;
  int  prev_cnt = 0, nxt_prev = 0, wcount_m = 0;
  bit  done_m = 0, ovf_m = 0, seen_m = 0, done_pre = 0, rdy_m = 0, wen_m = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  initial begin
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        exp_q.delete();
        prev_cnt = 0; wcount_m = 0; done_m = 0; ovf_m = 0; seen_m = 0;
        chk("rst_mem_wen", 32'(mem_wen), 32'd0);
        chk("rst_enc_ready", 32'(enc_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_mem_addr", mem_addr, BASE);
        chk("rst_mem_store", mem_store, 32'd0);
      end else begin
        rdy_m = (exp_q.size() < DEPTH) && !done_m && !seen_m;
        // A write is in progress once the FIFO has held data across an edge.
        wen_m = !done_m && prev_cnt > 0 && exp_q.size() > 0;
        chk("enc_ready", 32'(enc_ready), 32'(rdy_m));
        chk("mem_wen", 32'(mem_wen), 32'(wen_m));
        chk("done", 32'(done), 32'(done_m));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        chk("word_count", 32'(word_count), 32'(wcount_m));
        if (wen_m) begin
          chk("mem_store", mem_store, exp_q[0][31:0]);
          chk("mem_addr", mem_addr, BASE + 32'(4 * wcount_m));
        end
        if (mem_wen && !mem_wait) begin
          wr_addr.push_back(mem_addr);
          wr_data.push_back(mem_store);
          wr_cyc.push_back(cyc);
        end
        done_pre = done_m;
        nxt_prev = exp_q.size();
        if (wen_m && !mem_wait) begin
          ent = exp_q.pop_front();
          wcount_m++;
          if (ent[32]) done_m = 1;
          else if (wcount_m == MAXW) begin done_m = 1; ovf_m = 1; end
        end
        if (enc_valid && rdy_m) begin
          exp_q.push_back({enc_last, encode(enc_opcode, enc_rs, enc_rt, enc_rd, enc_shamt,
                                            enc_funct, enc_imm16, enc_imm26)});
          if (enc_last) seen_m = 1;
        end
        if (clear && done_pre) begin
          exp_q.delete();
          wcount_m = 0; done_m = 0; ovf_m = 0; seen_m = 0;
        end
        prev_cnt = nxt_prev;
      end
    end
  end

  task automatic set_fields(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
      input logic [15:0] i16, input logic [25:0] i26, input logic last);
    enc_opcode = op; enc_rs = rs; enc_rt = rt; enc_rd = rd; enc_shamt = sh;
    enc_funct = fn; enc_imm16 = i16; enc_imm26 = i26; enc_last = last;
  endtask

  // Entered and left at posedge+1; accepted on the edge after enc_ready is seen.
  task automatic push(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
      input logic [15:0] i16, input logic [25:0] i26, input logic last);
    int n = 0;
    set_fields(op, rs, rt, rd, sh, fn, i16, i26, last);
    enc_valid = 1'b1;
    forever begin
      @(negedge CLK);
      if (enc_ready) break;
      n++;
      if (n > 200) fail_timeout("push_accept");
    end
    @(posedge CLK); #1;
    enc_valid = 1'b0;
    enc_last  = 1'b0;
  endtask

  task automatic wait_writes(input int n, input string name);
    int k = 0;
    while (wr_data.size() < n) begin
      @(negedge CLK); #1;
      k++;
      if (k > 200) fail_timeout(name);
    end
    @(posedge CLK); #1;
  endtask

  task automatic wait_wen(input string name);
    int k = 0;
    forever begin
      @(negedge CLK); #1;
      if (mem_wen) break;
      k++;
      if (k > 200) fail_timeout(name);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge CLK); #1;
    clear = 1'b0;
  endtask

  int n0;

  initial begin
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;
    @(posedge CLK); #1;

    // ADDU and first-write latency
    n0 = wr_data.size();
    push(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0, 26'h0, 1'b0);
    chk("latency_idle_cycle", 32'(mem_wen), 32'd0);
    @(posedge CLK); #1;
    chk("latency_wen", 32'(mem_wen), 32'd1);
    wait_writes(n0 + 1, "addu_write");
    chk("addu_data", wr_data[n0], 32'h0022_1821);
    chk("addu_addr", wr_addr[n0], BASE);

    // ORI then J, written back-to-back
    n0 = wr_data.size();
    push(6'h0D, 5'd0, 5'd1, 5'd0, 5'd0, 6'h00, 16'h00F0, 26'h0, 1'b0);
    push(6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h100, 1'b0);
    wait_writes(n0 + 2, "ori_j_write");
    chk("ori_data", wr_data[n0], 32'h3401_00F0);
    chk("ori_addr", wr_addr[n0], BASE + 32'd4);
    chk("j_data", wr_data[n0+1], 32'h0800_0100);
    chk("j_addr", wr_addr[n0+1], BASE + 32'd8);
    chk("b2b_gap", 32'(wr_cyc[n0+1] - wr_cyc[n0]), 32'd1);

    // HALT as last word, held by mem_wait for 3 cycles
    n0 = wr_data.size();
    mem_wait = 1'b1;
    push(6'h3F, 5'd7, 5'd7, 5'd7, 5'd7, 6'h3F, 16'hFFFF, 26'h3FF_FFFF, 1'b1);
    wait_wen("halt_wen");
    for (int i = 0; i < 3; i++) begin
      chk("hold_wen", 32'(mem_wen), 32'd1);
      chk("hold_data", mem_store, 32'hFC00_0000);
      chk("hold_addr", mem_addr, BASE + 32'd12);
      @(posedge CLK); #1;
    end
    chk("hold_no_commit", 32'(wr_data.size()), 32'(n0));
    mem_wait = 1'b0;
    @(posedge CLK); #1;
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_word_count", 32'(word_count), 32'd4);
    chk("halt_ready_low", 32'(enc_ready), 32'd0);
    chk("halt_data", wr_data[n0], 32'hFC00_0000);
    pulse_clear();
    chk("clear_word_count", 32'(word_count), 32'd0);
    chk("clear_done", 32'(done), 32'd0);
    chk("clear_addr", mem_addr, BASE);

    // Stalled RAM: FIFO fills, fifth word blocked, order preserved
    n0 = wr_data.size();
    mem_wait = 1'b1;
    for (int i = 0; i < 4; i++)
      push(6'h09, 5'd0, 5'(i), 5'd0, 5'd0, 6'h00, 16'h1000 + 16'(i), 26'h0, 1'b0);
    set_fields(6'h09, 5'd0, 5'd4, 5'd0, 5'd0, 6'h00, 16'h1004, 26'h0, 1'b0);
    enc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("full_ready_low", 32'(enc_ready), 32'd0);
      @(posedge CLK); #1;
    end
    mem_wait = 1'b0;
    push(6'h09, 5'd0, 5'd4, 5'd0, 5'd0, 6'h00, 16'h1004, 26'h0, 1'b0);
    wait_writes(n0 + 5, "full_drain");
    for (int i = 0; i < 5; i++) begin
      chk("full_order_data", wr_data[n0+i], 32'h2400_1000 + 32'(i << 16) + 32'(i));
      chk("full_order_addr", wr_addr[n0+i], BASE + 32'(4 * i));
    end

    // Overflow: 5 more words with 5 already written and MAXW=8
    n0 = wr_data.size();
    for (int i = 0; i < 5; i++)
      push(6'h0F, 5'd0, 5'(i), 5'd0, 5'd0, 6'h00, 16'hBEE0 + 16'(i), 26'h0, 1'b0);
    repeat (4) @(posedge CLK);
    #1;
    chk("ovf_writes", 32'(wr_data.size() - n0), 32'd3);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_done", 32'(done), 32'd1);
    chk("ovf_word_count", 32'(word_count), 32'(MAXW));
    chk("ovf_wen_low", 32'(mem_wen), 32'd0);
    pulse_clear();
    chk("ovf_clear_count", 32'(word_count), 32'd0);
    chk("ovf_clear_flag", 32'(overflow), 32'd0);
    n0 = wr_data.size();
    push(6'h23, 5'd2, 5'd3, 5'd0, 5'd0, 6'h00, 16'h0010, 26'h0, 1'b1);
    wait_writes(n0 + 1, "post_clear_write");
    chk("post_clear_data", wr_data[n0], 32'h8C43_0010);
    chk("post_clear_addr", wr_addr[n0], BASE);
    pulse_clear();

    // Reset during a stalled write
    mem_wait = 1'b1;
    push(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0, 26'h0, 1'b0);
    wait_wen("rst_mid_wen");
    @(posedge CLK); #1;
    n0 = wr_data.size();
    nRST = 1'b0;
    #1;
    chk("rst_mid_wen_drop", 32'(mem_wen), 32'd0);
    chk("rst_mid_ready", 32'(enc_ready), 32'd0);
    mem_wait = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_after_done", 32'(done), 32'd0);
    chk("rst_after_wen", 32'(mem_wen), 32'd0);
    chk("rst_after_ready", 32'(enc_ready), 32'd1);
    chk("rst_after_no_write", 32'(wr_data.size()), 32'(n0));

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 5))
        0:       enc_opcode = 6'h00;
        1:       enc_opcode = 6'h02;
        2:       enc_opcode = 6'h03;
        3:       enc_opcode = 6'h3F;
        default: enc_opcode = 6'($urandom_range(4, 62));
      endcase
      enc_valid = 1'($urandom_range(0, 1));
      enc_rs    = 5'($urandom);
      enc_rt    = 5'($urandom);
      enc_rd    = 5'($urandom);
      enc_shamt = 5'($urandom);
      enc_funct = 6'($urandom);
      enc_imm16 = 16'($urandom);
      enc_imm26 = 26'($urandom);
      enc_last  = ($urandom_range(0, 7) == 0);
      mem_wait  = ($urandom_range(0, 3) == 0);
      clear     = ($urandom_range(0, 11) == 0);
      if (c == 1500) nRST = 1'b0;
      if (c == 1503) nRST = 1'b1;
      @(posedge CLK); #1;
    end
    enc_valid = 1'b0;
    clear     = 1'b0;
    mem_wait  = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    finish_run();
  end
endmodule
